// File: rtl/pwm_fade_if.sv
// Command and duty bus between the fade sequencer and its controller/PWM side.
// Start is a one-cycle strobe with no ready: it is accepted in any state
// unless Stop is high in the same cycle, and Mode/Target are sampled with it.
interface pwm_fade_if;
   logic [7:0] Q;
   logic       Start;
   logic [1:0] Mode;
   logic [7:0] Target;
   logic       Stop;
   logic [7:0] Duty;
   logic       Busy;
   logic       Done;
   logic [2:0] state_dbg;

   modport master (
      output Q, Start, Mode, Target, Stop,
      input  Duty, Busy, Done, state_dbg
   );

   modport slave (
      input  Q, Start, Mode, Target, Stop,
      output Duty, Busy, Done, state_dbg
   );
endinterface

// File: rtl/pwm_fade_ctrl.sv
// PWM duty sequencer: immediate set, linear fade and breathing, with every
// duty change aligned to the PWM wrap (Q == FF) so no period is truncated.
module pwm_fade_ctrl #(
   parameter int unsigned STEP_PERIODS = 4,
   parameter int unsigned STEP         = 1
) (
   input logic         CLOCK_50,
   input logic         Reset,
   pwm_fade_if.slave   bus
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SET   = 3'd1,
      S_FADE  = 3'd2,
      S_BR_UP = 3'd3,
      S_BR_DN = 3'd4
   } state_t;

   localparam logic [7:0] STEP_W  = 8'(STEP);
   localparam logic [7:0] PC_LAST = 8'(STEP_PERIODS - 1);

   state_t     state, state_nxt;
   logic [7:0] duty_q, duty_nxt;
   logic [7:0] t_q;
   logic [7:0] pc_q;
   logic       busy_q;
   logic       done_q, done_nxt;

   logic       tick, step, start_acc;
   logic [8:0] up_sum, dn_dif;
   logic [7:0] toward_t, dn_sat;

   function automatic state_t mode_state(input logic [1:0] m);
      case (m)
         2'b01:   return S_FADE;
         2'b10:   return S_BR_UP;
         default: return S_SET;
      endcase
   endfunction

   assign tick      = (bus.Q == 8'hFF);
   assign step      = tick && (pc_q == PC_LAST);
   assign start_acc = bus.Start && !bus.Stop;

   // 9-bit arithmetic so the carry/borrow tells us when to clamp.
   always_comb begin
      up_sum   = {1'b0, duty_q} + {1'b0, STEP_W};
      dn_dif   = {1'b0, duty_q} - {1'b0, STEP_W};
      dn_sat   = dn_dif[8] ? 8'd0 : dn_dif[7:0];
      toward_t = t_q;
      if (duty_q < t_q)
         toward_t = (up_sum > {1'b0, t_q}) ? t_q : up_sum[7:0];
      else if (duty_q > t_q)
         toward_t = (dn_dif[8] || (dn_dif[7:0] < t_q)) ? t_q : dn_dif[7:0];
   end

   always_ff @(posedge CLOCK_50) begin
      if (Reset) begin
         state  <= S_IDLE;
         duty_q <= 8'd0;
         t_q    <= 8'd0;
         pc_q   <= 8'd0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         state  <= state_nxt;
         duty_q <= duty_nxt;
         done_q <= done_nxt;
         busy_q <= (state_nxt != S_IDLE);
         if (start_acc)
            t_q <= bus.Target;
         if (start_acc || step)
            pc_q <= 8'd0;
         else if (tick)
            pc_q <= pc_q + 8'd1;
      end
   end

   always_comb begin
      state_nxt = state;
      if (state == S_IDLE) begin
         if (start_acc)
            state_nxt = mode_state(bus.Mode);
      end else if (bus.Stop) begin
         state_nxt = S_IDLE;
      end else if (bus.Start) begin
         state_nxt = mode_state(bus.Mode);
      end else begin
         case (state)
            S_SET:   if (tick) state_nxt = S_IDLE;
            S_FADE:  if (step && (toward_t == t_q)) state_nxt = S_IDLE;
            S_BR_UP: if (step && (toward_t == t_q)) state_nxt = S_BR_DN;
            S_BR_DN: if (step && (dn_sat == 8'd0)) state_nxt = S_BR_UP;
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   // A restart or abort consumes the current tick: no duty change, no Done.
   always_comb begin
      duty_nxt = duty_q;
      done_nxt = 1'b0;
      if ((state != S_IDLE) && !bus.Stop && !bus.Start) begin
         case (state)
            S_SET: if (tick) begin
               duty_nxt = t_q;
               done_nxt = 1'b1;
            end
            S_FADE: if (step) begin
               duty_nxt = toward_t;
               done_nxt = (toward_t == t_q);
            end
            S_BR_UP: if (step) duty_nxt = toward_t;
            S_BR_DN: if (step) duty_nxt = dn_sat;
            default: duty_nxt = duty_q;
         endcase
      end
   end

   assign bus.Duty      = duty_q;
   assign bus.Busy      = busy_q;
   assign bus.Done      = done_q;
   assign bus.state_dbg = state;

endmodule
